// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin arbiter sharing the register-bank write port between ALU and load writeback.
module regfile_wb_arbiter #(
  parameter int DATA_W           = 32,
  parameter int ADDR_W           = 5,
  parameter bit ZERO_REG_PROTECT = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              m_valid,
  output logic              m_ready,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [DATA_W-1:0] m_data,
  output logic              reg_en,
  output logic [ADDR_W-1:0] write_register,
  output logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] rr1,
  input  logic [ADDR_W-1:0] rr2,
  output logic              byp1,
  output logic              byp2
);
  // ptr_q: 0 favours A, 1 favours M under contention
  logic              ptr_q, ptr_d;
  logic              reg_en_q, reg_en_d;
  logic [ADDR_W-1:0] wr_q, wr_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic              gnt_a, gnt_m, xfer;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  always_comb begin
    gnt_a    = !rst && !stall && a_valid && (!m_valid || !ptr_q);
    gnt_m    = !rst && !stall && m_valid && (!a_valid || ptr_q);
    xfer     = gnt_a || gnt_m;
    sel_addr = gnt_a ? a_addr : m_addr;
    sel_data = gnt_a ? a_data : m_data;
    ptr_d    = (a_valid && m_valid && xfer) ? gnt_a : ptr_q;
    reg_en_d = xfer && !(ZERO_REG_PROTECT && sel_addr == '0);
    wr_d     = xfer ? sel_addr : wr_q;
    wd_d     = xfer ? sel_data : wd_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q    <= 1'b0;
      reg_en_q <= 1'b0;
      wr_q     <= '0;
      wd_q     <= '0;
    end else begin
      ptr_q    <= ptr_d;
      reg_en_q <= reg_en_d;
      wr_q     <= wr_d;
      wd_q     <= wd_d;
    end
  end

  assign a_ready        = gnt_a;
  assign m_ready        = gnt_m;
  assign reg_en         = reg_en_q;
  assign write_register = wr_q;
  assign write_data     = wd_q;
  assign byp1 = reg_en_q && (rr1 == wr_q) && !(ZERO_REG_PROTECT && rr1 == '0);
  assign byp2 = reg_en_q && (rr2 == wr_q) && !(ZERO_REG_PROTECT && rr2 == '0);
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: scoreboard bench with reference arbitration model for regfile_wb_arbiter.
module tb_regfile_wb_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  logic          clk = 1'b0;
  logic          rst, stall, a_valid, m_valid;
  logic [AW-1:0] a_addr, m_addr, rr1, rr2;
  logic [DW-1:0] a_data, m_data;
  logic          a_ready, m_ready, reg_en, byp1, byp2;
  logic [AW-1:0] write_register;
  logic [DW-1:0] write_data;

  typedef struct packed {logic [AW-1:0] addr; logic [DW-1:0] data;} req_t;
  typedef struct packed {logic en; logic [AW-1:0] addr; logic [DW-1:0] data;} wr_t;
  req_t qa[$];
  req_t qm[$];
  wr_t  sb[$];
  wr_t  mout;
  logic mptr;
  int   errors = 0;
  int   checks = 0;

  regfile_wb_arbiter dut (
    .clk(clk), .rst(rst), .stall(stall),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_data(m_data),
    .reg_en(reg_en), .write_register(write_register), .write_data(write_data),
    .rr1(rr1), .rr2(rr2), .byp1(byp1), .byp2(byp2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    a_valid = qa.size() != 0;
    m_valid = qm.size() != 0;
    a_addr  = a_valid ? qa[0].addr : '0;
    a_data  = a_valid ? qa[0].data : '0;
    m_addr  = m_valid ? qm[0].addr : '0;
    m_data  = m_valid ? qm[0].data : '0;
  endtask

  task automatic check_out(input string tag);
    check({tag, ".reg_en"}, reg_en, mout.en);
    check({tag, ".wreg"}, write_register, mout.addr);
    check({tag, ".wdata"}, write_data, mout.data);
    check({tag, ".byp1"}, byp1, mout.en && rr1 == mout.addr && rr1 != 0);
    check({tag, ".byp2"}, byp2, mout.en && rr2 == mout.addr && rr2 != 0);
  endtask

  task automatic tick(input string tag);
    logic ga, gm;
    wr_t  w;
    drive();
    #1;
    ga = !stall && a_valid && (!m_valid || !mptr);
    gm = !stall && m_valid && (!a_valid || mptr);
    check({tag, ".a_ready"}, a_ready, ga);
    check({tag, ".m_ready"}, m_ready, gm);
    if (ga) begin w.en = a_addr != 0; w.addr = a_addr; w.data = a_data; sb.push_back(w); end
    if (gm) begin w.en = m_addr != 0; w.addr = m_addr; w.data = m_data; sb.push_back(w); end
    if (a_valid && m_valid && (ga || gm)) mptr = ga;
    @(posedge clk);
    #1;
    if (ga) qa.delete(0);
    if (gm) qm.delete(0);
    if (sb.size() != 0) mout = sb.pop_front();
    else mout.en = 1'b0;
    check_out(tag);
  endtask

  task automatic push_a(input logic [AW-1:0] ad, input logic [DW-1:0] d);
    req_t r;
    r.addr = ad; r.data = d; qa.push_back(r);
  endtask

  task automatic push_m(input logic [AW-1:0] ad, input logic [DW-1:0] d);
    req_t r;
    r.addr = ad; r.data = d; qm.push_back(r);
  endtask

  task automatic model_reset();
    qa.delete(); qm.delete(); sb.delete();
    mptr = 1'b0;
    mout = '0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && (qa.size() != 0 || qm.size() != 0); i++) tick(tag);
    check({tag, ".drained"}, qa.size() + qm.size(), 0);
    tick({tag, ".idle"});
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; rr1 = '0; rr2 = '0;
    model_reset();
    drive();
    @(posedge clk);
    #2;
    check("rst.a_ready", a_ready, 0);
    check("rst.m_ready", m_ready, 0);
    check_out("rst");
    rst = 1'b0;
    // 1: single ALU write
    push_a(5'd5, 32'h1234);
    tick("t1");
    tick("t1.after");
    // 2: contention alternates A,M
    for (int i = 0; i < 4; i++) begin
      push_a(AW'(1 + i), 32'hA000 + i);
      push_m(AW'(9 + i), 32'hB000 + i);
    end
    drain("t2");
    // 3: M-only grants leave pointer at A
    push_m(5'd20, 32'h20);
    push_m(5'd21, 32'h21);
    tick("t3.m0");
    tick("t3.m1");
    push_a(5'd22, 32'h22);
    push_m(5'd23, 32'h23);
    drain("t3");
    // 4: register 0 is accepted but never written
    rr1 = '0;
    push_a('0, 32'hFFFF_FFFF);
    tick("t4");
    tick("t4.after");
    // 5: stall blocks both requesters
    stall = 1'b1;
    push_a(5'd14, 32'h14);
    push_m(5'd15, 32'h15);
    for (int i = 0; i < 3; i++) tick("t5.stall");
    stall = 1'b0;
    drain("t5");
    // 7: bypass hit on in-flight write
    rr1 = 5'd7; rr2 = 5'd8;
    push_a(5'd7, 32'h77);
    tick("t7");
    tick("t7.after");
    push_m(5'd8, 32'h88);
    tick("t7.m");
    tick("t7.m.after");
    // 6a: reset between acceptance and output edge drops the request
    push_a(5'd3, 32'hAAAA);
    drive();
    #1;
    check("t6a.a_ready", a_ready, 1);
    rst = 1'b1;
    #1;
    model_reset();
    drive();
    check("t6a.a_ready_rst", a_ready, 0);
    check_out("t6a.rst");
    @(posedge clk);
    #2;
    rst = 1'b0;
    tick("t6a.post");
    // 6b: reset while the write is on the bank port clears it at once
    push_m(5'd6, 32'h6666);
    tick("t6b");
    rst = 1'b1;
    #1;
    model_reset();
    check_out("t6b.rst");
    #2;
    rst = 1'b0;
    tick("t6b.post");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
